corr_peak_scan: RTL and testbench

//  Search controller sitting directly downstream of the correlation scorer.

---
 rtl/corr_peak_scan.sv | 142 ++++++++++++++
 tb/tb_corr_peak_scan.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/corr_peak_scan.sv
// corr_peak_scan: raster-scans candidate start coordinates over a window of
// the frame. It drives each candidate to the correlation scorer, collects the
// final scores, and reports the best-scoring position when the scan is done.
module corr_peak_scan #(
  parameter int COORD_W = 13,
  parameter int SCORE_W = 32,
  parameter int SCAN_X0 = 0,
  parameter int SCAN_Y0 = 0,
  parameter int SCAN_H  = 16,
  parameter int SCAN_V  = 16,
  parameter int STEP    = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic               iFinished,
  input  logic [SCORE_W-1:0] iScore,
  output logic [COORD_W-1:0] oXstart,
  output logic [COORD_W-1:0] oYstart,
  output logic               oCorrStart,
  output logic               oBusy,
  output logic               oDone,
  output logic [COORD_W-1:0] oBestX,
  output logic [COORD_W-1:0] oBestY,
  output logic [SCORE_W-1:0] oBestScore
);

  localparam int KXW = (SCAN_H > 1) ? $clog2(SCAN_H) : 1;
  localparam int KYW = (SCAN_V > 1) ? $clog2(SCAN_V) : 1;
  localparam logic [KXW-1:0] KX_LAST = KXW'(SCAN_H - 1);
  localparam logic [KYW-1:0] KY_LAST = KYW'(SCAN_V - 1);
  localparam logic [COORD_W-1:0] X0C   = COORD_W'(SCAN_X0);
  localparam logic [COORD_W-1:0] Y0C   = COORD_W'(SCAN_Y0);
  localparam logic [COORD_W-1:0] STEPC = COORD_W'(STEP);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_CLR, WAIT_FIN, SAMPLE, ADVANCE, DONE
  } state_t;

  state_t         state, stateNext;
  logic [KXW-1:0] kx;
  logic [KYW-1:0] ky;
  logic           lastCand;

  assign lastCand = (kx == KX_LAST) && (ky == KY_LAST);

  // State register; reset aborts any scan in progress
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state decode and control outputs derived from the current state
  always_comb begin
    stateNext  = state;
    oCorrStart = 1'b0;
    oBusy      = 1'b0;
    oDone      = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) stateNext = ISSUE;
      end
      ISSUE: begin
        oCorrStart = 1'b1;
        oBusy      = 1'b1;
        stateNext  = WAIT_CLR;
      end
      WAIT_CLR: begin
        // A flag still high from the previous candidate must drop first
        oBusy = 1'b1;
        if (!iFinished) stateNext = WAIT_FIN;
      end
      WAIT_FIN: begin
        oBusy = 1'b1;
        if (iFinished) stateNext = SAMPLE;
      end
      SAMPLE: begin
        oBusy     = 1'b1;
        stateNext = ADVANCE;
      end
      ADVANCE: begin
        oBusy     = 1'b1;
        stateNext = lastCand ? DONE : ISSUE;
      end
      DONE: begin
        oDone = 1'b1;
        if (iStart) stateNext = ISSUE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Candidate indices, candidate coordinates and best-match tracking.
  // Coordinates are stepped incrementally (modulo 2^COORD_W) and change only
  // on the edge that enters ISSUE, so they stay stable for the whole candidate.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      kx         <= '0;
      ky         <= '0;
      oXstart    <= '0;
      oYstart    <= '0;
      oBestX     <= '0;
      oBestY     <= '0;
      oBestScore <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            kx         <= '0;
            ky         <= '0;
            oXstart    <= X0C;
            oYstart    <= Y0C;
            oBestX     <= X0C;
            oBestY     <= Y0C;
            oBestScore <= '0;
          end
        end
        SAMPLE: begin
          // Strictly greater: ties keep the earlier candidate in raster order
          if (iScore > oBestScore) begin
            oBestScore <= iScore;
            oBestX     <= oXstart;
            oBestY     <= oYstart;
          end
        end
        ADVANCE: begin
          if (kx != KX_LAST) begin
            kx      <= kx + KXW'(1);
            oXstart <= oXstart + STEPC;
          end else if (ky != KY_LAST) begin
            kx      <= '0;
            ky      <= ky + KYW'(1);
            oXstart <= X0C;
            oYstart <= oYstart + STEPC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_peak_scan.sv
// Directed bench for corr_peak_scan on a 2x2 window at (8,8), step 4,
// with a behavioural scorer whose delay, stale-flag time and scores are set per test.
module tb_corr_peak_scan;

  localparam int CW = 13;
  localparam int SW = 32;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iStart;
  logic          iFinished;
  logic [SW-1:0] iScore;
  logic [CW-1:0] oXstart, oYstart, oBestX, oBestY;
  logic          oCorrStart, oBusy, oDone;
  logic [SW-1:0] oBestScore;

  int checks = 0;
  int errors = 0;

  int scoreTab[4];
  int delayTab[4];
  int staleCfg;
  int candIdx;
  int pulses;
  bit running;
  int staleCnt;
  int busyCnt;
  logic [CW-1:0] lastX, lastY, expX, expY;

  corr_peak_scan #(
    .COORD_W(CW), .SCORE_W(SW), .SCAN_X0(8), .SCAN_Y0(8),
    .SCAN_H(2), .SCAN_V(2), .STEP(4)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFinished(iFinished),
    .iScore(iScore), .oXstart(oXstart), .oYstart(oYstart),
    .oCorrStart(oCorrStart), .oBusy(oBusy), .oDone(oDone),
    .oBestX(oBestX), .oBestY(oBestY), .oBestScore(oBestScore)
  );

  always #10 iCLK = ~iCLK;

  // Scorer model: on each restart pulse it keeps the flag high for staleCfg
  // cycles, drops it, then raises it with the candidate's score after the delay.
  always @(negedge iCLK) begin
    if (iRST) begin
      candIdx   = 0;
      running   = 1'b0;
      iFinished = 1'b0;
    end else if (oCorrStart) begin
      checks++;
      assert (running === 1'b0) else begin
        errors++; $error("FAIL earlyIssue observed=running required=idle cand=%0d", candIdx);
      end
      expX = CW'(8 + 4 * (candIdx % 2));
      expY = CW'(8 + 4 * ((candIdx / 2) % 2));
      checks++;
      assert (oXstart === expX && oYstart === expY && candIdx < 4) else begin
        errors++; $error("FAIL issueCoord cand=%0d observed=(%0d,%0d) expected=(%0d,%0d)",
                         candIdx, oXstart, oYstart, expX, expY);
      end
      checks++;
      assert (oBusy === 1'b1) else begin
        errors++; $error("FAIL busyInIssue observed=%b expected=1", oBusy);
      end
      pulses++;
      lastX    = oXstart;
      lastY    = oYstart;
      running  = 1'b1;
      staleCnt = staleCfg;
      busyCnt  = delayTab[candIdx % 4];
      if (staleCnt == 0) iFinished = 1'b0;
    end else begin
      if (oBusy) begin
        checks++;
        assert (oXstart === lastX && oYstart === lastY) else begin
          errors++; $error("FAIL coordStable observed=(%0d,%0d) expected=(%0d,%0d)",
                           oXstart, oYstart, lastX, lastY);
        end
      end
      if (running) begin
        if (staleCnt > 0) begin
          staleCnt--;
          if (staleCnt == 0) iFinished = 1'b0;
        end else if (busyCnt > 0) begin
          busyCnt--;
        end else begin
          iFinished = 1'b1;
          iScore    = SW'(scoreTab[candIdx % 4]);
          candIdx++;
          running   = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic startScan();
    @(negedge iCLK);
    pulses  = 0;
    candIdx = 0;
    iStart  = 1'b1;
    @(negedge iCLK);
    iStart  = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (oDone === 1'b1) break;
      @(negedge iCLK);
    end
    chk({tag, "_doneReached"}, 32'(oDone), 32'd1);
  endtask

  task automatic waitPulses(input int n);
    for (int i = 0; i < 500; i++) begin
      if (pulses >= n) break;
      @(negedge iCLK);
    end
    chk("pulseReached", 32'(pulses), 32'(n));
  endtask

  task automatic checkResult(input string tag, input int x, input int y, input int s);
    chk({tag, "_busy"},   32'(oBusy),   32'd0);
    chk({tag, "_bestX"},  32'(oBestX),  32'(x));
    chk({tag, "_bestY"},  32'(oBestY),  32'(y));
    chk({tag, "_score"},  oBestScore,   32'(s));
    chk({tag, "_pulses"}, 32'(pulses),  32'd4);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_x"},     32'(oXstart),    32'd0);
    chk({tag, "_y"},     32'(oYstart),    32'd0);
    chk({tag, "_corr"},  32'(oCorrStart), 32'd0);
    chk({tag, "_busy"},  32'(oBusy),      32'd0);
    chk({tag, "_done"},  32'(oDone),      32'd0);
    chk({tag, "_bestX"}, 32'(oBestX),     32'd0);
    chk({tag, "_bestY"}, 32'(oBestY),     32'd0);
    chk({tag, "_score"}, oBestScore,      32'd0);
  endtask

  initial begin
    iRST      = 1'b1;
    iStart    = 1'b0;
    iFinished = 1'b0;
    iScore    = '0;
    staleCfg  = 0;
    pulses    = 0;
    candIdx   = 0;
    running   = 1'b0;
    lastX     = '0;
    lastY     = '0;
    scoreTab  = '{100, 300, 300, 50};
    delayTab  = '{3, 3, 3, 3};

    #25;
    checkAllZero("reset");
    @(negedge iCLK);
    iRST = 1'b0;

    // Basic scan: later 300 ties the earlier one and must not win
    startScan();
    waitDone("basic");
    checkResult("basic", 12, 8, 300);

    // All-zero scores: best stays at the window origin with score 0
    scoreTab = '{0, 0, 0, 0};
    startScan();
    waitDone("zeros");
    checkResult("zeros", 8, 8, 0);

    // Stale finished flag held into each new candidate
    scoreTab = '{40, 30, 900, 10};
    staleCfg = 4;
    startScan();
    waitDone("stale");
    checkResult("stale", 8, 12, 900);
    staleCfg = 0;

    // Reset while waiting on the third candidate, then a clean rescan
    scoreTab = '{1, 2, 3, 4};
    delayTab = '{3, 3, 2000, 3};
    startScan();
    waitPulses(3);
    repeat (10) @(negedge iCLK);
    chk("midScanBusy", 32'(oBusy), 32'd1);
    #3 iRST = 1'b1;
    #1 checkAllZero("asyncRst");
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    delayTab = '{3, 3, 3, 3};
    repeat (3) @(negedge iCLK);
    chk("postRstIdleBusy", 32'(oBusy), 32'd0);
    chk("postRstIdleDone", 32'(oDone), 32'd0);
    startScan();
    waitDone("rescan");
    checkResult("rescan", 12, 12, 4);

    // Start pulse mid-scan is ignored
    scoreTab = '{100, 300, 300, 50};
    delayTab = '{5, 5, 5, 5};
    startScan();
    waitPulses(2);
    @(negedge iCLK);
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    waitDone("midStart");
    checkResult("midStart", 12, 8, 300);

    // Widely varied scorer latency
    delayTab = '{1, 500, 7, 250};
    startScan();
    waitDone("delays");
    checkResult("delays", 12, 8, 300);
    chk("delays_doneHeld", 32'(oDone), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
